crc32_fcs_tx: RTL and testbench
===============================

Name: crc32_fcs_tx

Overview:
- Byte-stream framer for the Ethernet TX path. Passes payload bytes through and zero-pads short frames to MIN_LEN bytes.
- Appends the 4-byte IEEE 802.3 FCS, computed by one instance of the existing crc_32_d8 byte engine.
- Sits between the packet source (valid/ready byte stream with last) and the MAC/PHY byte serializer.
- Sequences the engine itself: init pulse, enable per covered byte, FCS capture.

Parameters:
- MIN_LEN, 60, minimum payload-plus-pad length in bytes before FCS; 0 disables padding; legal range 0..255.
- CW, 8, width of the byte counter; must satisfy 2^CW > MIN_LEN.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- s_data  in  8  input payload byte.
- s_valid  in  1  input byte valid.
- s_last  in  1  marks the final payload byte of a frame.
- s_ready  out  1  block accepts s_data this cycle.
- m_data  out  8  output byte (payload, pad or FCS).
- m_valid  out  1  output byte valid.
- m_last  out  1  set on the final FCS byte.
- m_ready  in  1  downstream accepts m_data.
- fcs  out  32  FCS of the most recent frame, as transmitted (byte 0 = fcs[7:0]).
- frame_done  out  1  one-cycle pulse when the final FCS byte transfers.

Behaviour:
- Reset values: m_valid=0, m_last=0, m_data=0, fcs=0, frame_done=0, state=IDLE, counters=0. Reset mid-frame discards the frame; the next frame starts clean.
- Output register: m_data/m_valid/m_last are registered, one entry deep. Define load_ok = !m_valid | m_ready. A byte presented or generated in cycle N appears on m_* in cycle N+1.
- s_ready = load_ok & (state==IDLE | state==DATA). s_fire = s_valid & s_ready. m_fire = m_valid & m_ready.
- Engine instance: crc_32_d8 with MSBFIRST=0, INIT=32'hffffffff, VXOR=32'hffffffff.
  - en = s_fire, or a pad byte being loaded.
  - d_in = s_data, or 8'h00 for pad.
  - Engine reset input crc_init = (state==FCS) | (state==IDLE & !s_fire), so the engine holds INIT before every frame, including back-to-back frames.
  - Engine crc output is valid only in cycles with en=1. fcs is captured from it in the cycle the last covered byte enters the engine.
- Byte counter cnt: cleared in IDLE; +1 per payload or pad byte loaded; saturates at MIN_LEN.
- States:
  - IDLE: on s_fire, load the byte and cnt=1. If s_last, apply the end-of-payload rule; else go to DATA.
  - DATA: on s_fire, load the byte and increment cnt. If s_last, apply the end-of-payload rule.
  - End-of-payload rule: if cnt after this byte >= MIN_LEN, capture fcs now and go to FCS. Otherwise go to PAD.
  - PAD: s_ready=0. When load_ok, load 8'h00 and increment cnt. When cnt reaches MIN_LEN, capture fcs (on that pad byte) and go to FCS.
  - FCS: s_ready=0. 2-bit idx. When load_ok, load fcs[8*idx+:8] and increment idx. On idx==3, set m_last on that byte and go to IDLE.
- frame_done pulses on m_fire with m_last=1.
- A frame exactly MIN_LEN bytes long produces no pad. A 1-byte frame (s_last on the first byte) is legal.
- s_last without s_valid is ignored. m_ready held low stalls all states; no byte is dropped or duplicated.
- Throughput: one byte per cycle sustained. The next frame may be accepted in the cycle after the final FCS byte is loaded.

Decomposition:
- Shared package: state encoding (IDLE, DATA, PAD, FCS) and constants CRC32_INIT=32'hffffffff, CRC32_XOR=32'hffffffff, CRC32_RESIDUE=32'hC704DD7B.
- Sub-module: the existing crc_32_d8 (one instance). No other sub-module.

Test Plan:
- MIN_LEN=0, payload ASCII "123456789" (31..39), m_ready=1. Expect m_data 31..39 then 26,39,F4,CB; m_last on CB; fcs=32'hCBF43926; frame_done pulses once.
- MIN_LEN=60, 1-byte frame 8'hAA. Expect AA, then 59 bytes of 00, then 4 FCS bytes (64 total). s_ready=0 during PAD/FCS. FCS matches a software CRC-32 over the 60 bytes.
- MIN_LEN=60, 60-byte frame. Expect no pad bytes; FCS bytes follow the last payload byte directly.
- Random m_ready toggling (~50%) plus random s_valid gaps on the "123456789" frame. Expect an identical output byte sequence and fcs=32'hCBF43926.
- Two back-to-back "123456789" frames with s_valid held high. Expect frame 2 accepted in the cycle after frame 1's final FCS byte is loaded; both FCS equal 32'hCBF43926.
- Assert reset during FCS byte 2. Expect m_valid=0 immediately (asynchronously). A following "123456789" frame produces a correct FCS of 32'hCBF43926.

Source files
------------

// File: rtl/crc32_fcs_tx_pkg.sv
// Shared state encoding and CRC-32 constants for the Ethernet FCS framer.
package crc32_fcs_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAD,
    FCS
  } state_e;

  localparam logic [31:0] CRC32_INIT      = 32'hffffffff;
  localparam logic [31:0] CRC32_XOR       = 32'hffffffff;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hC704DD7B;
  localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;

endpackage

// File: rtl/crc_32_d8.sv
// Byte-wide CRC-32 engine. crc is the finalised value after absorbing d_in and is
// only meaningful in cycles with en=1.
module crc_32_d8
  import crc32_fcs_tx_pkg::*;
#(
  parameter bit          MSBFIRST = 1'b0,
  parameter logic [31:0] INIT     = CRC32_INIT,
  parameter logic [31:0] VXOR     = CRC32_XOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        crc_init,
  input  logic        en,
  input  logic [7:0]  d_in,
  output logic [31:0] crc
);

  logic [31:0] c_q;
  logic [31:0] c_nxt;

  always_comb begin
    logic [31:0] c;
    logic        fb;
    c  = c_q;
    fb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (MSBFIRST) begin
        fb = c[31] ^ d_in[7-i];
        c  = {c[30:0], 1'b0} ^ ({32{fb}} & CRC32_POLY);
      end else begin
        fb = c[0] ^ d_in[i];
        c  = {1'b0, c[31:1]} ^ ({32{fb}} & CRC32_POLY_REFL);
      end
    end
    c_nxt = c;
  end

  assign crc = c_nxt ^ VXOR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_q <= INIT;
    end else if (crc_init) begin
      c_q <= INIT;
    end else if (en) begin
      c_q <= c_nxt;
    end
  end

endmodule

// File: rtl/crc32_fcs_tx.sv
// Ethernet TX framer: passes payload, zero-pads to MIN_LEN and appends the
// 4-byte FCS (least significant byte first) through a one-deep output register.
module crc32_fcs_tx
  import crc32_fcs_tx_pkg::*;
#(
  parameter int unsigned MIN_LEN = 60,
  parameter int unsigned CW      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic [31:0] fcs,
  output logic        frame_done
);

  localparam logic [CW-1:0] MinLen = CW'(MIN_LEN);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_base, cnt_inc;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;
  logic [31:0]   fcs_q, fcs_d;
  logic          load_ok, s_fire;
  logic          crc_en, crc_init;
  logic [7:0]    crc_din;
  logic [31:0]   crc_out;

  assign load_ok    = !m_valid_q | m_ready;
  assign s_ready    = load_ok & ((state_q == IDLE) | (state_q == DATA));
  assign s_fire     = s_valid & s_ready;
  // Holding INIT whenever no frame is in flight covers back-to-back frames too.
  assign crc_init   = (state_q == FCS) | ((state_q == IDLE) & !s_fire);
  assign cnt_base   = (state_q == IDLE) ? '0 : cnt_q;
  assign cnt_inc    = (cnt_base >= MinLen) ? cnt_base : cnt_base + CW'(1);

  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign fcs        = fcs_q;
  assign frame_done = m_valid_q & m_ready & m_last_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    fcs_d     = fcs_q;
    crc_en    = 1'b0;
    crc_din   = s_data;

    if (load_ok) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    unique case (state_q)
      IDLE, DATA: begin
        if (s_fire) begin
          crc_en    = 1'b1;
          m_data_d  = s_data;
          m_valid_d = 1'b1;
          cnt_d     = cnt_inc;
          state_d   = DATA;
          if (s_last) begin
            if (cnt_inc >= MinLen) begin
              fcs_d   = crc_out;
              state_d = FCS;
              idx_d   = 2'd0;
              cnt_d   = '0;
            end else begin
              state_d = PAD;
            end
          end
        end
      end
      PAD: begin
        if (load_ok) begin
          crc_en    = 1'b1;
          crc_din   = 8'h00;
          m_data_d  = 8'h00;
          m_valid_d = 1'b1;
          cnt_d     = cnt_inc;
          if (cnt_inc >= MinLen) begin
            fcs_d   = crc_out;
            state_d = FCS;
            idx_d   = 2'd0;
            cnt_d   = '0;
          end
        end
      end
      FCS: begin
        if (load_ok) begin
          m_data_d  = fcs_q[{idx_q, 3'b000} +: 8];
          m_valid_d = 1'b1;
          idx_d     = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            m_last_d = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      m_data_q  <= 8'h00;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      fcs_q     <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      fcs_q     <= fcs_d;
    end
  end

  crc_32_d8 #(
    .MSBFIRST(1'b0),
    .INIT    (CRC32_INIT),
    .VXOR    (CRC32_XOR)
  ) u_crc (
    .clk     (clk),
    .reset   (reset),
    .crc_init(crc_init),
    .en      (crc_en),
    .d_in    (crc_din),
    .crc     (crc_out)
  );

endmodule

// File: tb/tb_crc32_fcs_tx.sv
// Bench for crc32_fcs_tx: one instance without padding, one with MIN_LEN=60,
// checked against a table-driven CRC-32 and a byte-list frame model.
module tb_crc32_fcs_tx;

  localparam int M0 = 0;
  localparam int M1 = 60;

  logic        clk;
  logic        reset;
  logic [7:0]  s_data     [2];
  logic        s_valid    [2];
  logic        s_last     [2];
  logic        s_ready    [2];
  logic [7:0]  m_data     [2];
  logic        m_valid    [2];
  logic        m_last     [2];
  logic        m_ready    [2];
  logic [31:0] fcs        [2];
  logic        frame_done [2];

  int checks = 0;
  int errors = 0;

  logic [31:0] crc_tab [256];
  logic [7:0]  pay [$];

  crc32_fcs_tx #(.MIN_LEN(M0), .CW(8)) u_dut0 (
    .clk       (clk),
    .reset     (reset),
    .s_data    (s_data[0]),
    .s_valid   (s_valid[0]),
    .s_last    (s_last[0]),
    .s_ready   (s_ready[0]),
    .m_data    (m_data[0]),
    .m_valid   (m_valid[0]),
    .m_last    (m_last[0]),
    .m_ready   (m_ready[0]),
    .fcs       (fcs[0]),
    .frame_done(frame_done[0])
  );

  crc32_fcs_tx #(.MIN_LEN(M1), .CW(8)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .s_data    (s_data[1]),
    .s_valid   (s_valid[1]),
    .s_last    (s_last[1]),
    .s_ready   (s_ready[1]),
    .m_data    (m_data[1]),
    .m_valid   (m_valid[1]),
    .m_last    (m_last[1]),
    .m_ready   (m_ready[1]),
    .fcs       (fcs[1]),
    .frame_done(frame_done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_crc(input logic [7:0] b [$]);
    logic [31:0] c;
    c = 32'hffffffff;
    foreach (b[i]) c = crc_tab[(c[7:0] ^ b[i])] ^ (c >> 8);
    return ~c;
  endfunction

  // Sends nfr copies of pay on instance sel; abort_after>0 returns after that many
  // output transfers.
  task automatic run(input int sel, input int nfr, input bit rnd, input int abort_after);
    logic [7:0]  exp_q [$];
    logic [31:0] exp_fcs [$];
    logic [7:0]  body [$];
    logic [31:0] c;
    int ml, pi, fi, nout, ndone, per, lastvis, cyc;
    bit stop;
    ml = (sel == 0) ? M0 : M1;
    for (int f = 0; f < nfr; f++) begin
      body = pay;
      while (body.size() < ml) body.push_back(8'h00);
      c = ref_crc(body);
      exp_fcs.push_back(c);
      foreach (body[i]) exp_q.push_back(body[i]);
      for (int k = 0; k < 4; k++) exp_q.push_back(8'(c >> (8 * k)));
    end
    per = exp_q.size() / nfr;
    pi = 0; fi = 0; nout = 0; ndone = 0; lastvis = -1; stop = 1'b0;
    for (cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (fi < nfr && (!rnd || $urandom_range(0, 9) < 7)) begin
        s_valid[sel] = 1'b1;
        s_data[sel]  = pay[pi];
        s_last[sel]  = (pi == pay.size() - 1);
      end else begin
        s_valid[sel] = 1'b0;
        s_data[sel]  = 8'($urandom);
        s_last[sel]  = 1'($urandom);
      end
      m_ready[sel] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (m_valid[sel] && m_last[sel]) lastvis = cyc;
      if (fi > ndone && !(m_valid[sel] && m_last[sel])) chk("s_ready_low", s_ready[sel], 1'b0);
      chk("frame_done", frame_done[sel], m_valid[sel] & m_ready[sel] & m_last[sel]);
      if (m_valid[sel] && m_ready[sel]) begin
        if (nout < exp_q.size()) chk("m_data", m_data[sel], exp_q[nout]);
        else chk("extra_byte", nout, exp_q.size());
        chk("m_last", m_last[sel], ((nout % per) == per - 1));
        nout++;
        if (m_last[sel]) begin
          if (ndone < nfr) chk("fcs", fcs[sel], exp_fcs[ndone]);
          ndone++;
        end
        if (abort_after > 0 && nout == abort_after) stop = 1'b1;
      end
      if (s_valid[sel] && s_ready[sel]) begin
        if (pi == 0 && fi > 0 && !rnd) chk("b2b_accept", cyc, lastvis);
        pi++;
        if (pi == pay.size()) begin
          pi = 0;
          fi++;
        end
      end
      if (stop || ndone == nfr) break;
    end
    @(posedge clk);
    #1;
    s_valid[sel] = 1'b0;
    s_last[sel]  = 1'b0;
    m_ready[sel] = 1'b1;
    if (abort_after == 0) begin
      chk("frames_done", ndone, nfr);
      chk("out_count", nout, exp_q.size());
    end
  endtask

  task automatic load_digits();
    pay.delete();
    for (int i = 0; i < 9; i++) pay.push_back(8'(8'h31 + i));
  endtask

  initial begin
    logic [31:0] t;
    int len;
    for (int n = 0; n < 256; n++) begin
      t = 32'(n);
      for (int k = 0; k < 8; k++) t = t[0] ? ((t >> 1) ^ 32'hEDB88320) : (t >> 1);
      crc_tab[n] = t;
    end

    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      s_data[s] = 8'h00; s_valid[s] = 1'b0; s_last[s] = 1'b0; m_ready[s] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_m_valid", m_valid[s], 1'b0);
      chk("rst_m_last", m_last[s], 1'b0);
      chk("rst_m_data", m_data[s], 8'h00);
      chk("rst_fcs", fcs[s], 32'h0);
      chk("rst_frame_done", frame_done[s], 1'b0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("idle_s_ready", s_ready[1], 1'b1);

    // Check value, no padding
    load_digits();
    run(0, 1, 1'b0, 0);
    chk("check_value", fcs[0], 32'hCBF43926);

    // 1-byte frame padded to 60
    pay.delete();
    pay.push_back(8'hAA);
    run(1, 1, 1'b0, 0);

    // Exactly MIN_LEN bytes: no pad
    pay.delete();
    for (int i = 0; i < 60; i++) pay.push_back(8'($urandom));
    run(1, 1, 1'b0, 0);

    // Random flow control on both instances
    load_digits();
    run(0, 1, 1'b1, 0);
    chk("rnd_check_value", fcs[0], 32'hCBF43926);
    run(1, 1, 1'b1, 0);

    // Back-to-back frames with s_valid held high
    load_digits();
    run(0, 2, 1'b0, 0);
    chk("b2b_check_value", fcs[0], 32'hCBF43926);

    // Reset asserted while FCS byte 2 is in flight
    load_digits();
    run(0, 1, 1'b0, 11);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_m_valid", m_valid[0], 1'b0);
    chk("async_m_last", m_last[0], 1'b0);
    chk("async_fcs", fcs[0], 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    run(0, 1, 1'b0, 0);
    chk("post_reset_value", fcs[0], 32'hCBF43926);

    // Random payloads of random length
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 80);
      pay.delete();
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
      run(r % 2, $urandom_range(1, 2), 1'(r < 4), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
